// File: rtl/pc_gen.sv
// Fetch-PC generator: registered virtual/physical PC and TLB flags, advancing by
// 0..FETCH_W slots or loading a redirect. Optional hold feature: PC_GEN_REDIRECT_HOLD_EN.

module pc_gen_lane #(
    parameter int unsigned SLOT = 0
) (
    input  logic [31:0] pc_i,
    output logic [31:0] vaddr_o
);
    assign vaddr_o = pc_i + 32'(4 * (SLOT + 1));
endmodule

module pc_gen #(
    parameter int unsigned FETCH_W     = 2,
    parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
    parameter logic [31:0] RESET_PADDR = 32'h1fc0_0000,
    parameter logic [3:0]  RESET_TLB   = 4'b0001
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pc_en,
    input  logic                       fifo_full,
    input  logic [FETCH_W-1:0]         inst_ok,
    input  logic                       exception_taken,
    input  logic [31:0]                exception_address,
    input  logic                       branch_en,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_address,
    output logic [31:0]                redir_vaddr,
    input  logic [31:0]                redir_paddr,
    input  logic [3:0]                 redir_tlb,
    output logic [FETCH_W-1:0][31:0]   seq_vaddr,
    input  logic [FETCH_W-1:0][31:0]   seq_paddr,
    input  logic [FETCH_W-1:0][3:0]    seq_tlb,
    output logic [31:0]                pc_address,
    output logic [31:0]                pc_address_psy,
    output logic [3:0]                 tlb_flags,
    output logic                       redirect_pending,
    output logic                       redirect_fire
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] paddr_q, paddr_d;
    logic [3:0]  tlb_q, tlb_d;
    logic        fire_q, fire_d;

    logic        exc_new, br_new;
    logic        redir_vld;
    logic [31:0] redir_tgt;

    logic        seq_run;
    logic [31:0] sel_vaddr, sel_paddr;
    logic [3:0]  sel_tlb;

    assign exc_new = exception_taken;
    assign br_new  = branch_en && branch_taken;

    // Sequential candidates come only from the registered PC, so the ITLB
    // lookup never sees inst_ok.
    for (genvar k = 0; k < FETCH_W; k++) begin : g_lane
        pc_gen_lane #(.SLOT(k)) u_lane (
            .pc_i    (pc_q),
            .vaddr_o (seq_vaddr[k])
        );
    end

    // Pick the last slot of the leading run of accepted instructions.
    always_comb begin
        seq_run   = 1'b1;
        sel_vaddr = pc_q;
        sel_paddr = paddr_q;
        sel_tlb   = tlb_q;
        for (int k = 0; k < FETCH_W; k++) begin
            if (seq_run && inst_ok[k]) begin
                sel_vaddr = seq_vaddr[k];
                sel_paddr = seq_paddr[k];
                sel_tlb   = seq_tlb[k];
            end else begin
                seq_run = 1'b0;
            end
        end
    end

`ifdef PC_GEN_REDIRECT_HOLD_EN
    // A held exception and a held branch resolve identically (exceptions always
    // overwrite, branches never overwrite), so only target and valid are kept.
    logic        hold_vld_q, hold_vld_d;
    logic [31:0] hold_addr_q, hold_addr_d;

    always_comb begin
        redir_vld = 1'b0;
        redir_tgt = branch_address;
        if (exc_new) begin
            redir_vld = 1'b1;
            redir_tgt = exception_address;
        end else if (hold_vld_q) begin
            redir_vld = 1'b1;
            redir_tgt = hold_addr_q;
        end else if (br_new) begin
            redir_vld = 1'b1;
            redir_tgt = branch_address;
        end
    end

    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_addr_d = hold_addr_q;
        if (pc_en) begin
            if (redir_vld) hold_vld_d = 1'b0;
        end else if (exc_new) begin
            hold_vld_d  = 1'b1;
            hold_addr_d = exception_address;
        end else if (br_new && !hold_vld_q) begin
            hold_vld_d  = 1'b1;
            hold_addr_d = branch_address;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    assign redirect_pending = hold_vld_q;
`else
    always_comb begin
        redir_vld = 1'b0;
        redir_tgt = branch_address;
        if (exc_new) begin
            redir_vld = 1'b1;
            redir_tgt = exception_address;
        end else if (br_new) begin
            redir_vld = 1'b1;
            redir_tgt = branch_address;
        end
    end

    assign redirect_pending = 1'b0;
`endif

    assign redir_vaddr = redir_tgt;

    // Redirects bypass fifo_full and inst_ok; sequential advance needs both.
    always_comb begin
        pc_d    = pc_q;
        paddr_d = paddr_q;
        tlb_d   = tlb_q;
        fire_d  = 1'b0;
        if (pc_en) begin
            if (redir_vld) begin
                pc_d    = redir_tgt;
                paddr_d = redir_paddr;
                tlb_d   = redir_tlb;
                fire_d  = 1'b1;
            end else if (!fifo_full && inst_ok[0]) begin
                pc_d    = sel_vaddr;
                paddr_d = sel_paddr;
                tlb_d   = sel_tlb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            paddr_q <= RESET_PADDR;
            tlb_q   <= RESET_TLB;
            fire_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            paddr_q <= paddr_d;
            tlb_q   <= tlb_d;
            fire_q  <= fire_d;
        end
    end

    assign pc_address     = pc_q;
    assign pc_address_psy = paddr_q;
    assign tlb_flags      = tlb_q;
    assign redirect_fire  = fire_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen (FETCH_W=2); ITLB modelled as vaddr & 0x1fff_ffff.

module tb_pc_gen;
    localparam int unsigned FW = 2;
`ifdef PC_GEN_REDIRECT_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pc_en, fifo_full;
    logic [FW-1:0]     inst_ok;
    logic              exception_taken, branch_en, branch_taken;
    logic [31:0]       exception_address, branch_address;
    logic [31:0]       redir_vaddr, redir_paddr;
    logic [3:0]        redir_tlb;
    logic [FW-1:0][31:0] seq_vaddr, seq_paddr;
    logic [FW-1:0][3:0]  seq_tlb;
    logic [31:0]       pc_address, pc_address_psy;
    logic [3:0]        tlb_flags;
    logic              redirect_pending, redirect_fire;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign redir_paddr = redir_vaddr & 32'h1fff_ffff;
    for (genvar k = 0; k < FW; k++) begin : g_tlb
        assign seq_paddr[k] = seq_vaddr[k] & 32'h1fff_ffff;
        assign seq_tlb[k]   = 4'(k + 2);
    end

    pc_gen #(.FETCH_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .fifo_full(fifo_full),
        .inst_ok(inst_ok), .exception_taken(exception_taken),
        .exception_address(exception_address), .branch_en(branch_en),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .redir_vaddr(redir_vaddr), .redir_paddr(redir_paddr), .redir_tlb(redir_tlb),
        .seq_vaddr(seq_vaddr), .seq_paddr(seq_paddr), .seq_tlb(seq_tlb),
        .pc_address(pc_address), .pc_address_psy(pc_address_psy),
        .tlb_flags(tlb_flags), .redirect_pending(redirect_pending),
        .redirect_fire(redirect_fire)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic en, input logic [31:0] a);
        branch_en = en; branch_taken = en; branch_address = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_en = 1'b0; fifo_full = 1'b0; inst_ok = '0;
        exception_taken = 1'b0; exception_address = '0; redir_tlb = '0;
        set_branch(1'b0, 32'h0);
        #12;
        n_cmp++; if (pc_address !== 32'hbfc0_0000) begin n_err++; $display("FAIL reset_pc got %h exp bfc00000", pc_address); end
        n_cmp++; if (pc_address_psy !== 32'h1fc0_0000) begin n_err++; $display("FAIL reset_psy got %h exp 1fc00000", pc_address_psy); end
        n_cmp++; if (tlb_flags !== 4'b0001) begin n_err++; $display("FAIL reset_tlb got %b exp 0001", tlb_flags); end
        n_cmp++; if (redirect_pending !== 1'b0 || redirect_fire !== 1'b0) begin n_err++; $display("FAIL reset_flags got %b%b exp 00", redirect_pending, redirect_fire); end
        n_cmp++; if (seq_vaddr[0] !== 32'hbfc0_0004 || seq_vaddr[1] !== 32'hbfc0_0008) begin n_err++; $display("FAIL reset_seq got %h %h exp bfc00004 bfc00008", seq_vaddr[0], seq_vaddr[1]); end
    endtask

    task automatic test_advance();
        rst_n = 1'b1; pc_en = 1'b1; inst_ok = 2'b11;
        tick();
        n_cmp++; if (pc_address !== 32'hbfc0_0008) begin n_err++; $display("FAIL adv2_pc got %h exp bfc00008", pc_address); end
        n_cmp++; if (pc_address_psy !== 32'h1fc0_0008) begin n_err++; $display("FAIL adv2_psy got %h exp 1fc00008", pc_address_psy); end
        n_cmp++; if (tlb_flags !== 4'd3 || redirect_fire !== 1'b0) begin n_err++; $display("FAIL adv2_tlb got %h fire %b exp 3 0", tlb_flags, redirect_fire); end
        inst_ok = 2'b01;
        tick();
        n_cmp++; if (pc_address !== 32'hbfc0_000c || tlb_flags !== 4'd2) begin n_err++; $display("FAIL adv1 got %h/%h exp bfc0000c/2", pc_address, tlb_flags); end
    endtask

    task automatic test_partial();
        inst_ok = 2'b00; redir_tlb = 4'b0100; set_branch(1'b1, 32'h8000_0000);
        tick();
        n_cmp++; if (pc_address !== 32'h8000_0000 || pc_address_psy !== 32'h0 || tlb_flags !== 4'b0100) begin n_err++; $display("FAIL br_load got %h %h %b exp 80000000 0 0100", pc_address, pc_address_psy, tlb_flags); end
        n_cmp++; if (redirect_fire !== 1'b1) begin n_err++; $display("FAIL br_fire got %b exp 1", redirect_fire); end
        set_branch(1'b0, 32'h0); inst_ok = 2'b10;
        tick();
        n_cmp++; if (pc_address !== 32'h8000_0000 || redirect_fire !== 1'b0) begin n_err++; $display("FAIL ok10_hold got %h fire %b exp 80000000 0", pc_address, redirect_fire); end
        inst_ok = 2'b01;
        tick();
        n_cmp++; if (pc_address !== 32'h8000_0004 || pc_address_psy !== 32'h4 || tlb_flags !== 4'd2) begin n_err++; $display("FAIL ok01 got %h %h %h exp 80000004 4 2", pc_address, pc_address_psy, tlb_flags); end
    endtask

    task automatic test_fifo_full();
        fifo_full = 1'b1; inst_ok = 2'b11; redir_tlb = 4'b0000; set_branch(1'b1, 32'h8000_1000);
        tick();
        n_cmp++; if (pc_address !== 32'h8000_1000 || redirect_fire !== 1'b1) begin n_err++; $display("FAIL ff_branch got %h fire %b exp 80001000 1", pc_address, redirect_fire); end
        set_branch(1'b0, 32'h0);
        tick();
        n_cmp++; if (pc_address !== 32'h8000_1000 || redirect_fire !== 1'b0) begin n_err++; $display("FAIL ff_hold got %h fire %b exp 80001000 0", pc_address, redirect_fire); end
        fifo_full = 1'b0;
    endtask

    task automatic test_priority();
        inst_ok = 2'b00; redir_tlb = 4'b1010;
        exception_taken = 1'b1; exception_address = 32'hbfc0_0380; set_branch(1'b1, 32'h8000_2000);
        #1;
        n_cmp++; if (redir_vaddr !== 32'hbfc0_0380) begin n_err++; $display("FAIL prio_vaddr got %h exp bfc00380", redir_vaddr); end
        tick();
        n_cmp++; if (pc_address !== 32'hbfc0_0380 || pc_address_psy !== 32'h1fc0_0380 || tlb_flags !== 4'b1010) begin n_err++; $display("FAIL prio_load got %h %h %b exp bfc00380 1fc00380 1010", pc_address, pc_address_psy, tlb_flags); end
        exception_taken = 1'b0; set_branch(1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        redir_tlb = 4'b0000; set_branch(1'b1, 32'hffff_fffc);
        tick();
        set_branch(1'b0, 32'h0);
        n_cmp++; if (seq_vaddr[0] !== 32'h0 || seq_vaddr[1] !== 32'h4) begin n_err++; $display("FAIL wrap_seq got %h %h exp 0 4", seq_vaddr[0], seq_vaddr[1]); end
        inst_ok = 2'b01;
        tick();
        n_cmp++; if (pc_address !== 32'h0 || pc_address_psy !== 32'h0 || tlb_flags !== 4'd2) begin n_err++; $display("FAIL wrap_pc got %h %h %h exp 0 0 2", pc_address, pc_address_psy, tlb_flags); end
    endtask

    task automatic test_hold();
        pc_en = 1'b0; inst_ok = 2'b00; redir_tlb = 4'b0110; set_branch(1'b1, 32'h8000_3000);
        tick();
        n_cmp++; if (redirect_pending !== HOLD || pc_address !== 32'h0 || redirect_fire !== 1'b0) begin n_err++; $display("FAIL hold_br got pend %b pc %h fire %b exp %b 0 0", redirect_pending, pc_address, redirect_fire, HOLD); end
        set_branch(1'b0, 32'h0); exception_taken = 1'b1; exception_address = 32'hbfc0_0380;
        tick();
        exception_taken = 1'b0; set_branch(1'b1, 32'h8000_4000);
        tick();
        n_cmp++; if (redirect_pending !== HOLD || pc_address !== 32'h0) begin n_err++; $display("FAIL hold_exc got pend %b pc %h exp %b 0", redirect_pending, pc_address, HOLD); end
        branch_en = 1'b0; branch_taken = 1'b0; pc_en = 1'b1;
        #1;
        n_cmp++; if (redir_vaddr !== (HOLD ? 32'hbfc0_0380 : 32'h8000_4000)) begin n_err++; $display("FAIL hold_vaddr got %h exp %h", redir_vaddr, HOLD ? 32'hbfc0_0380 : 32'h8000_4000); end
        tick();
        n_cmp++; if (pc_address !== (HOLD ? 32'hbfc0_0380 : 32'h0)) begin n_err++; $display("FAIL hold_apply got %h exp %h", pc_address, HOLD ? 32'hbfc0_0380 : 32'h0); end
        n_cmp++; if (redirect_fire !== HOLD || redirect_pending !== 1'b0) begin n_err++; $display("FAIL hold_flags got fire %b pend %b exp %b 0", redirect_fire, redirect_pending, HOLD); end
        if (HOLD) begin
            n_cmp++; if (tlb_flags !== 4'b0110) begin n_err++; $display("FAIL hold_tlb got %b exp 0110", tlb_flags); end
        end
        tick();
        n_cmp++; if (redirect_fire !== 1'b0) begin n_err++; $display("FAIL hold_fire_pulse got %b exp 0", redirect_fire); end
    endtask

    task automatic test_reset_mid_hold();
        set_branch(1'b1, 32'h8000_0000);
        tick();
        pc_en = 1'b0; set_branch(1'b1, 32'h8000_5000);
        tick();
        set_branch(1'b0, 32'h8000_5000);
        n_cmp++; if (pc_address !== 32'h8000_0000 || redirect_pending !== HOLD) begin n_err++; $display("FAIL rst_pre got %h pend %b exp 80000000 %b", pc_address, redirect_pending, HOLD); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pc_address !== 32'hbfc0_0000 || pc_address_psy !== 32'h1fc0_0000 || tlb_flags !== 4'b0001) begin n_err++; $display("FAIL rst_async got %h %h %b exp bfc00000 1fc00000 0001", pc_address, pc_address_psy, tlb_flags); end
        n_cmp++; if (redirect_pending !== 1'b0) begin n_err++; $display("FAIL rst_pend got %b exp 0", redirect_pending); end
        #1;
        rst_n = 1'b1; pc_en = 1'b1;
        tick();
        n_cmp++; if (pc_address !== 32'hbfc0_0000 || redirect_fire !== 1'b0) begin n_err++; $display("FAIL rst_noapply got %h fire %b exp bfc00000 0", pc_address, redirect_fire); end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_partial();
        test_fifo_full();
        test_priority();
        test_wrap();
        test_hold();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-PC generator for the instruction-fetch front end: holds the virtual fetch PC, its physical translation and TLB flags, and advances by 0..FETCH_W instructions per cycle. Redirects from exception or branch take priority. It drives candidate virtual addresses to the ITLB and registers the matching translation alongside the PC. A redirect arriving while fetch is disabled is held rather than lost.

## Interface
- FETCH_W, 2, instructions fetched per cycle (1..4); sequential candidate k is pc+4*(k+1)
- RESET_PC, 32'hbfc0_0000, virtual PC after reset
- RESET_PADDR, 32'h1fc0_0000, physical PC after reset
- RESET_TLB, 4'b0001, TLB flags after reset ({miss, illegal, invalid, uncached})
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- pc_en  in  1  fetch advance enable
- fifo_full  in  1  instruction FIFO full; holds sequential advance only
- inst_ok  in  FETCH_W  per-slot fetch accepted; advance count is number of consecutive ones from bit 0
- exception_taken  in  1  exception redirect request
- exception_address  in  32  exception target
- branch_en  in  1  branch resolution valid
- branch_taken  in  1  branch taken
- branch_address  in  32  branch target
- redir_vaddr  out  32  redirect candidate sent to ITLB (combinational)
- redir_paddr  in  32  translation of redir_vaddr
- redir_tlb  in  4  flags for redir_vaddr
- seq_vaddr  out  32*FETCH_W  sequential candidates, slot k at bits [32k+31:32k]
- seq_paddr  in  32*FETCH_W  translations of seq_vaddr
- seq_tlb  in  4*FETCH_W  flags per slot, slot k at [4k+3:4k]
- pc_address  out  32  current virtual fetch PC (registered)
- pc_address_psy  out  32  current physical fetch PC (registered)
- tlb_flags  out  4  {miss, illegal, invalid, uncached} for current PC (registered)
- redirect_pending  out  1  a held redirect awaits application (registered)
- redirect_fire  out  1  a redirect was loaded into the PC this cycle (registered pulse)

## Operation
- Reset (rst_n=0, any time): pc_address=RESET_PC, pc_address_psy=RESET_PADDR, tlb_flags=RESET_TLB, redirect_pending=0, redirect_fire=0. Held redirect is discarded.
- New redirect this cycle: exception_taken, else (branch_en && branch_taken).
- Effective redirect, in priority order:
  - new exception;
  - else held redirect;
  - else new branch.
- redir_vaddr carries the effective redirect target. When no redirect is active it carries branch_address.
- pc_en=1, effective redirect present: load target, redir_paddr and redir_tlb. Clear the hold. Pulse redirect_fire. fifo_full and inst_ok are ignored.
- pc_en=1, no redirect, fifo_full=1: hold all state.
- pc_en=1, no redirect, fifo_full=0, n=advance count:
  - n=0: hold.
  - n>0: load slot n-1 (pc+4n, its seq_paddr and seq_tlb).
  - Ones after the first zero in inst_ok are ignored.
- pc_en=0: PC state holds. A new redirect is captured into the hold (target plus type):
  - exception overwrites a held branch;
  - a branch does not overwrite a held exception or an older held branch.
- Arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0x0000_0000. No alignment checking.

## Timing
- One-cycle latency: a redirect or advance decided at edge t appears on pc_address, pc_address_psy and tlb_flags after edge t+1.
- ITLB is combinational. redir_paddr, redir_tlb, seq_paddr and seq_tlb must be valid in the same cycle as the vaddr outputs.
- seq_vaddr depends only on registered pc_address, so there is no combinational path from inst_ok.
- redirect_fire is high for exactly one cycle after each load. redirect_pending rises the cycle after capture and falls the cycle the hold is applied.

## Configuration
- PC_GEN_REDIRECT_HOLD_EN defined: hold register, redirect_pending and the capture/priority rules above are present.
- Not defined: no hold register. A redirect with pc_en=0 is dropped, redirect_pending is tied 0, and the priority reduces to exception > branch.

## Test plan
- Reset release, FETCH_W=2, pc_en=1, inst_ok=2'b11, seq_paddr slot1=0x1fc0_0008 -> pc_address 0xbfc0_0000 then 0xbfc0_0008, pc_address_psy 0x1fc0_0008, tlb_flags from seq_tlb slot1.
- inst_ok=2'b10 then 2'b01 from pc=0x8000_0000 -> hold at 0x8000_0000, then 0x8000_0004.
- fifo_full=1 with branch to 0x8000_1000 -> pc=0x8000_1000 next cycle, redirect_fire=1 for one cycle. Without the branch, fifo_full=1 holds the pc.
- Same cycle exception 0xbfc0_0380 and branch 0x8000_2000 -> pc=0xbfc0_0380, tlb_flags=redir_tlb.
- HOLD_EN: pc_en=0, branch 0x8000_3000, then exception 0xbfc0_0380, then pc_en=1 -> redirect_pending=1, pc=0xbfc0_0380, redirect_pending=0. Without the macro, pc is unchanged.
- Assert rst_n mid-hold, pc=0x8000_0000 -> pc=0xbfc0_0000 and redirect_pending=0 immediately. After release with pc_en=1, no held redirect is applied.
